light_phase_ctrl: RTL and testbench

Traffic-light phase controller that uses the 32-bit reversible counter as its phase timer. Per phase it drives the counter's `Load`, `PData` and `s` inputs and advances on the counter's `Rc` pulse. It also latches pedestrian requests, sequences GREEN → YELLOW → RED (→ WALK) → GREEN, and exposes lamp, walk and cycle-count outputs to the Exp10 top level.

---
 rtl/light_pkg.sv | 20 ++
 rtl/light_phase_ctrl.sv | 83 ++++++++
 tb/tb_light_phase_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/light_pkg.sv
// light_pkg: shared phase/lamp encodings and timer constants for light_phase_ctrl
package light_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GREEN  = 3'd1,
    YELLOW = 3'd2,
    RED    = 3'd3,
    WALK   = 3'd4
  } phase_t;
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam int MIN_PHASE = 3;
  localparam int LOAD_LAT  = 3;
  // load -> counter load -> terminal count -> Rc register costs LOAD_LAT edges
  function automatic logic [31:0] preload(input int t);
    return 32'(t - LOAD_LAT);
  endfunction
endpackage

// File: rtl/light_phase_ctrl.sv
// light_phase_ctrl: traffic-light phase FSM driving an external down-counter as phase timer
//   clk, rst_n        clock, async active-low reset
//   run               level enable, 0 forces IDLE
//   ped_req           pedestrian request level
//   Rc                counter terminal-count pulse
//   Load/PData/s      counter load strobe, preload value, direction (0 = down)
//   state/light/walk  current phase and lamps
//   phase_tick        pulse on phase entry
//   cycles_done       completed GREEN-to-GREEN cycles (wrapping)
module light_phase_ctrl
  import light_pkg::*;
#(
  parameter int T_GREEN  = 10,
  parameter int T_YELLOW = 4,
  parameter int T_RED    = 8,
  parameter int T_WALK   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        ped_req,
  input  logic        Rc,
  output logic        Load,
  output logic [31:0] PData,
  output logic        s,
  output logic [2:0]  state,
  output logic [2:0]  light,
  output logic        walk,
  output logic        phase_tick,
  output logic [7:0]  cycles_done
);
  phase_t st, nxt;
  logic load_q, ped_pending, rc_ok, enter, ped_n;
  logic [31:0] pdata_n;
  logic [2:0] light_n;
  logic [7:0] cyc_n;
  int t_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      load_q      <= 1'b0;
      Load        <= 1'b0;
      phase_tick  <= 1'b0;
      PData       <= '0;
      light       <= LAMP_OFF;
      walk        <= 1'b0;
      ped_pending <= 1'b0;
      cycles_done <= '0;
    end else begin
      st          <= nxt;
      load_q      <= Load;
      Load        <= enter;
      phase_tick  <= enter;
      PData       <= pdata_n;
      light       <= light_n;
      walk        <= nxt == WALK;
      ped_pending <= ped_n;
      cycles_done <= cyc_n;
    end
  end
  // Rc is ignored while a load is in flight: the counter still holds the old phase's value
  always_comb begin
    rc_ok = Rc && !Load && !load_q && st != IDLE;
    nxt   = !run           ? IDLE :
            st == IDLE     ? GREEN :
            !rc_ok         ? st :
            st == GREEN    ? YELLOW :
            st == YELLOW   ? RED :
            st == RED      ? (ped_pending ? WALK : GREEN) : GREEN;
  end
  always_comb begin
    enter   = nxt != st && nxt != IDLE;
    t_nxt   = nxt == GREEN ? T_GREEN : nxt == YELLOW ? T_YELLOW : nxt == RED ? T_RED : T_WALK;
    pdata_n = nxt == IDLE ? '0 : enter ? preload(t_nxt) : PData;
    light_n = nxt == GREEN ? LAMP_G : nxt == YELLOW ? LAMP_Y :
              (nxt == RED || nxt == WALK) ? LAMP_R : LAMP_OFF;
    ped_n   = (nxt == IDLE || (nxt == WALK && st != WALK)) ? 1'b0 :
              (ped_req && st != IDLE) ? 1'b1 : ped_pending;
    cyc_n   = cycles_done + 8'((nxt == GREEN && (st == RED || st == WALK)) ? 1 : 0);
  end
  assign s     = 1'b0;
  assign state = st;
endmodule

// File: tb/tb_light_phase_ctrl.sv
// tb_light_phase_ctrl: table/scoreboard bench for light_phase_ctrl with a behavioural up/down counter
module tb_light_phase_ctrl;
  logic clk, rst_n, run, ped_req, rc_force;
  logic Load, s, walk, phase_tick;
  logic [31:0] PData;
  logic [2:0] state, light;
  logic [7:0] cycles_done;
  logic [31:0] cnt = 32'd5;
  logic rc_m = 1'b0;
  logic run3, Load3, s3, walk3, tick3;
  logic [31:0] PData3;
  logic [2:0] state3, light3;
  logic [7:0] cd3;
  logic [31:0] cnt3 = 32'd9;
  logic rc3 = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic        run;
    logic        ped;
    int          cyc;
    logic [2:0]  st;
    logic [2:0]  lt;
    logic        ld;
    logic [31:0] pd;
    logic        wk;
    logic [7:0]  cd;
  } vec_t;
  vec_t tbl[19];
  vec_t exp_q[$];
  vec_t e;

  light_phase_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ped_req(ped_req), .Rc(rc_m | rc_force),
    .Load(Load), .PData(PData), .s(s), .state(state), .light(light), .walk(walk),
    .phase_tick(phase_tick), .cycles_done(cycles_done)
  );

  light_phase_ctrl #(.T_GREEN(3), .T_YELLOW(3), .T_RED(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .run(run3), .ped_req(1'b0), .Rc(rc3),
    .Load(Load3), .PData(PData3), .s(s3), .state(state3), .light(light3), .walk(walk3),
    .phase_tick(tick3), .cycles_done(cd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // free-running reversible counter: Rc registered one edge after terminal count
  always @(posedge clk) begin
    cnt  <= Load ? PData : s ? cnt + 1 : cnt - 1;
    rc_m <= s ? &cnt : cnt == 0;
    cnt3 <= Load3 ? PData3 : s3 ? cnt3 + 1 : cnt3 - 1;
    rc3  <= s3 ? &cnt3 : cnt3 == 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; ped_req = 1'b0; rc_force = 1'b0; run3 = 1'b0;
    #12 rst_n = 1'b1;
    tick(1);
    chk("reset_state", {29'd0, state}, 0);
    chk("reset_load", {31'd0, Load}, 0);
    chk("reset_cd", {24'd0, cycles_done}, 0);
    //              run ped cyc st lt      ld pd wk cd
    tbl[0]  = '{1'b0, 1'b0, 2,  3'd0, 3'b000, 1'b0, 0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1,  3'd1, 3'b001, 1'b1, 7, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1,  3'd1, 3'b001, 1'b0, 7, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0, 9,  3'd2, 3'b010, 1'b1, 1, 1'b0, 0};
    tbl[4]  = '{1'b1, 1'b0, 4,  3'd3, 3'b100, 1'b1, 5, 1'b0, 0};
    tbl[5]  = '{1'b1, 1'b0, 8,  3'd1, 3'b001, 1'b1, 7, 1'b0, 1};
    tbl[6]  = '{1'b1, 1'b0, 10, 3'd2, 3'b010, 1'b1, 1, 1'b0, 1};
    tbl[7]  = '{1'b1, 1'b1, 1,  3'd2, 3'b010, 1'b0, 1, 1'b0, 1};
    tbl[8]  = '{1'b1, 1'b0, 3,  3'd3, 3'b100, 1'b1, 5, 1'b0, 1};
    tbl[9]  = '{1'b1, 1'b0, 8,  3'd4, 3'b100, 1'b1, 3, 1'b1, 1};
    tbl[10] = '{1'b1, 1'b0, 6,  3'd1, 3'b001, 1'b1, 7, 1'b0, 2};
    tbl[11] = '{1'b1, 1'b0, 10, 3'd2, 3'b010, 1'b1, 1, 1'b0, 2};
    tbl[12] = '{1'b1, 1'b0, 4,  3'd3, 3'b100, 1'b1, 5, 1'b0, 2};
    tbl[13] = '{1'b1, 1'b0, 8,  3'd1, 3'b001, 1'b1, 7, 1'b0, 3};
    tbl[14] = '{1'b1, 1'b0, 5,  3'd1, 3'b001, 1'b0, 7, 1'b0, 3};
    tbl[15] = '{1'b0, 1'b0, 1,  3'd0, 3'b000, 1'b0, 0, 1'b0, 3};
    tbl[16] = '{1'b1, 1'b0, 1,  3'd1, 3'b001, 1'b1, 7, 1'b0, 3};
    tbl[17] = '{1'b1, 1'b0, 9,  3'd1, 3'b001, 1'b0, 7, 1'b0, 3};
    tbl[18] = '{1'b1, 1'b0, 1,  3'd2, 3'b010, 1'b1, 1, 1'b0, 3};
    for (int i = 0; i < 19; i++) begin
      run = tbl[i].run;
      ped_req = tbl[i].ped;
      exp_q.push_back(tbl[i]);
      tick(tbl[i].cyc);
      e = exp_q.pop_front();
      chk($sformatf("v%0d_state", i), {29'd0, state}, {29'd0, e.st});
      chk($sformatf("v%0d_light", i), {29'd0, light}, {29'd0, e.lt});
      chk($sformatf("v%0d_load", i), {31'd0, Load}, {31'd0, e.ld});
      chk($sformatf("v%0d_tick", i), {31'd0, phase_tick}, {31'd0, e.ld});
      chk($sformatf("v%0d_pdata", i), PData, e.pd);
      chk($sformatf("v%0d_walk", i), {31'd0, walk}, {31'd0, e.wk});
      chk($sformatf("v%0d_cd", i), {24'd0, cycles_done}, {24'd0, e.cd});
      chk($sformatf("v%0d_s", i), {31'd0, s}, 0);
    end
    // Rc held high through the load cycle and the one after must not end GREEN early
    run = 1'b0;
    tick(2);
    chk("hold_idle", {29'd0, state}, 0);
    run = 1'b1;
    tick(1);
    rc_force = 1'b1;
    chk("hold_e0_green", {29'd0, state}, 1);
    chk("hold_e0_load", {31'd0, Load}, 1);
    tick(1);
    chk("hold_e1_green", {29'd0, state}, 1);
    tick(1);
    rc_force = 1'b0;
    chk("hold_e2_green", {29'd0, state}, 1);
    tick(7);
    chk("hold_e9_green", {29'd0, state}, 1);
    tick(1);
    chk("hold_e10_yellow", {29'd0, state}, 2);
    // asynchronous reset in the middle of RED
    tick(4);
    chk("pre_rst_red", {29'd0, state}, 3);
    tick(3);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_state", {29'd0, state}, 0);
    chk("arst_light", {29'd0, light}, 0);
    chk("arst_load", {31'd0, Load}, 0);
    chk("arst_pdata", PData, 0);
    chk("arst_cd", {24'd0, cycles_done}, 0);
    chk("arst_tick", {31'd0, phase_tick}, 0);
    chk("arst_walk", {31'd0, walk}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_green", {29'd0, state}, 1);
    chk("post_rst_load", {31'd0, Load}, 1);
    chk("post_rst_cd", {24'd0, cycles_done}, 0);
    run = 1'b0;
    // minimum-length phases and cycles_done wrap
    run3 = 1'b1;
    tick(1);
    chk("t3_green", {29'd0, state3}, 1);
    chk("t3_pdata", PData3, 0);
    chk("t3_load", {31'd0, Load3}, 1);
    for (int i = 0; i < 256; i++) begin
      tick(2);
      chk("t3_green_hold", {29'd0, state3}, 1);
      tick(1);
      chk("t3_yellow", {29'd0, state3}, 2);
      chk("t3_yellow_pd", PData3, 0);
      tick(3);
      chk("t3_red", {29'd0, state3}, 3);
      tick(3);
      chk("t3_cycle_green", {29'd0, state3}, 1);
      chk("t3_cd", {24'd0, cd3}, 32'((i + 1) % 256));
    end
    chk("t3_wrap", {24'd0, cd3}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
